// File: rtl/conv2d_ctrl_pkg.sv
// Shared state encoding, default geometry and helpers for the conv2d sequencer.
// Pure declarations: no latency, no flow control.
package conv2d_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_COMMIT,
    ST_READY,
    ST_ISSUE,
    ST_WAIT,
    ST_HOLD
  } state_t;

  localparam int DEF_INPUT_WIDTH    = 32;
  localparam int DEF_INPUT_HEIGHT   = 1;
  localparam int DEF_INPUT_CHANNELS = 1;
  localparam int DEF_KERNEL_SIZE    = 3;
  localparam int DEF_NUM_FILTERS    = 8;
  localparam int DEF_ACTIV_BITS     = 8;
  localparam int DEF_TIMEOUT        = 15;

  localparam int NW        = DEF_NUM_FILTERS * DEF_INPUT_CHANNELS * DEF_KERNEL_SIZE * DEF_KERNEL_SIZE;
  localparam int NB        = DEF_NUM_FILTERS;
  localparam int FB        = DEF_INPUT_WIDTH * DEF_INPUT_HEIGHT * DEF_INPUT_CHANNELS * DEF_ACTIV_BITS;
  localparam int CFG_BYTES = NW + NB;

  // Counter width able to index 0..n-1, never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/conv2d_ctrl_if.sv
// Config-byte, frame and result handshakes between a producer/consumer and the sequencer.
// Wiring only: no latency; ready/valid semantics are owned by the slave.
interface conv2d_ctrl_if #(
  parameter int AB = 8,
  parameter int FB = 256
) ();
  logic          cfg_start;
  logic          cfg_valid;
  logic [AB-1:0] cfg_data;
  logic          cfg_ready;
  logic          frame_valid;
  logic [FB-1:0] frame_data;
  logic          frame_ready;
  logic          result_valid;
  logic          result_ready;

  modport master (
    output cfg_start, cfg_valid, cfg_data, frame_valid, frame_data, result_ready,
    input  cfg_ready, frame_ready, result_valid
  );

  modport slave (
    input  cfg_start, cfg_valid, cfg_data, frame_valid, frame_data, result_ready,
    output cfg_ready, frame_ready, result_valid
  );
endinterface

// File: rtl/conv2d_cfg_deser.sv
// Byte-serial to flat weight/bias deserialiser; one byte per accept, done on the final byte.
// No internal stall: the parent gates accept, and clear rewinds the byte index only.
import conv2d_ctrl_pkg::*;

module conv2d_cfg_deser #(
  parameter int NW = 72,
  parameter int NB = 8,
  parameter int AB = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              accept,
  input  logic [AB-1:0]     data,
  output logic              done,
  output logic [NW*AB-1:0]  weights,
  output logic [NB*AB-1:0]  biases
);
  localparam int CW = cnt_bits(NW + NB);
  localparam logic [CW-1:0] LAST = CW'(NW + NB - 1);

  logic [CW-1:0] cnt;

  assign done = accept && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      weights <= '0;
      biases  <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      if (int'(cnt) < NW) begin
        weights[int'(cnt)*AB +: AB] <= data;
      end else begin
        biases[(int'(cnt)-NW)*AB +: AB] <= data;
      end
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/conv2d_ctrl.sv
// Sequencer for one conv2d: loads weights/biases, then issues one frame at a time, 4 cycles/frame.
// Result is held in HOLD until taken; no new frame is accepted while a result is pending.
import conv2d_ctrl_pkg::*;

module conv2d_ctrl #(
  parameter int INPUT_WIDTH    = DEF_INPUT_WIDTH,
  parameter int INPUT_HEIGHT   = DEF_INPUT_HEIGHT,
  parameter int INPUT_CHANNELS = DEF_INPUT_CHANNELS,
  parameter int KERNEL_SIZE    = DEF_KERNEL_SIZE,
  parameter int NUM_FILTERS    = DEF_NUM_FILTERS,
  parameter int ACTIV_BITS     = DEF_ACTIV_BITS,
  parameter int TIMEOUT        = DEF_TIMEOUT,
  localparam int W_BYTES    = NUM_FILTERS * INPUT_CHANNELS * KERNEL_SIZE * KERNEL_SIZE,
  localparam int B_BYTES    = NUM_FILTERS,
  localparam int FRAME_BITS = INPUT_WIDTH * INPUT_HEIGHT * INPUT_CHANNELS * ACTIV_BITS
) (
  input  logic                          clk,
  input  logic                          rst,
  conv2d_ctrl_if.slave                  bus,
  output logic [FRAME_BITS-1:0]         conv_data_in,
  output logic                          conv_data_valid,
  output logic [W_BYTES*ACTIV_BITS-1:0] conv_weights,
  output logic [B_BYTES*ACTIV_BITS-1:0] conv_biases,
  output logic                          conv_load_w,
  output logic                          conv_load_b,
  input  logic                          conv_out_valid,
  output logic [15:0]                   frame_count,
  output logic                          err_timeout,
  output logic                          configured
);
  localparam int TW = cnt_bits(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_t        state;
  logic [TW-1:0] tmo_cnt;
  logic          cfg_done;
  logic          cfg_clear;
  logic          cfg_accept;

  assign bus.cfg_ready    = (state == ST_LOAD);
  assign bus.frame_ready  = (state == ST_READY);
  assign bus.result_valid = (state == ST_HOLD);

  // A restart wins over a byte presented in the same cycle; that byte is dropped.
  assign cfg_clear  = bus.cfg_start &&
                      (state == ST_IDLE || state == ST_READY || state == ST_LOAD);
  assign cfg_accept = (state == ST_LOAD) && bus.cfg_valid && !bus.cfg_start;

  conv2d_cfg_deser #(
    .NW (W_BYTES),
    .NB (B_BYTES),
    .AB (ACTIV_BITS)
  ) u_deser (
    .clk     (clk),
    .rst     (rst),
    .clear   (cfg_clear),
    .accept  (cfg_accept),
    .data    (bus.cfg_data),
    .done    (cfg_done),
    .weights (conv_weights),
    .biases  (conv_biases)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      tmo_cnt         <= '0;
      conv_data_in    <= '0;
      conv_data_valid <= 1'b0;
      conv_load_w     <= 1'b0;
      conv_load_b     <= 1'b0;
      frame_count     <= '0;
      err_timeout     <= 1'b0;
      configured      <= 1'b0;
    end else begin
      conv_data_valid <= 1'b0;
      conv_load_w     <= 1'b0;
      conv_load_b     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.cfg_start) begin
            err_timeout <= 1'b0;
            state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (cfg_done) begin
            conv_load_w <= 1'b1;
            conv_load_b <= 1'b1;
            state       <= ST_COMMIT;
          end
        end
        ST_COMMIT: begin
          configured <= 1'b1;
          state      <= ST_READY;
        end
        ST_READY: begin
          if (bus.cfg_start) begin
            configured  <= 1'b0;
            err_timeout <= 1'b0;
            state       <= ST_LOAD;
          end else if (bus.frame_valid) begin
            conv_data_in    <= bus.frame_data;
            conv_data_valid <= 1'b1;
            state           <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          tmo_cnt <= '0;
          state   <= ST_WAIT;
        end
        ST_WAIT: begin
          // The last counted WAIT cycle is TIMEOUT-1, giving exactly TIMEOUT WAIT cycles.
          if (conv_out_valid) begin
            state <= ST_HOLD;
          end else if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= ST_READY;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_HOLD: begin
          if (bus.result_ready) begin
            frame_count <= frame_count + 16'd1;
            state       <= ST_READY;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv2d_ctrl.sv
// Directed bench for conv2d_ctrl with a 1-cycle conv2d valid model and a tie-off for timeouts.
module tb_conv2d_ctrl;
  localparam int FBITS = 256;
  localparam int WBITS = 72 * 8;
  localparam int BBITS = 8 * 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [FBITS-1:0]  conv_data_in;
  logic              conv_data_valid;
  logic [WBITS-1:0]  conv_weights;
  logic [BBITS-1:0]  conv_biases;
  logic              conv_load_w;
  logic              conv_load_b;
  logic              conv_out_valid = 1'b0;
  logic [15:0]       frame_count;
  logic              err_timeout;
  logic              configured;
  logic              tie_off = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  int lw_cnt = 0;
  int lb_cnt = 0;
  int dv_cnt = 0;

  conv2d_ctrl_if #(.AB(8), .FB(FBITS)) bus ();

  conv2d_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .conv_data_in    (conv_data_in),
    .conv_data_valid (conv_data_valid),
    .conv_weights    (conv_weights),
    .conv_biases     (conv_biases),
    .conv_load_w     (conv_load_w),
    .conv_load_b     (conv_load_b),
    .conv_out_valid  (conv_out_valid),
    .frame_count     (frame_count),
    .err_timeout     (err_timeout),
    .configured      (configured)
  );

  always #5 clk = ~clk;

  // conv2d stand-in: data_out_valid one cycle after data_valid.
  always @(posedge clk) begin
    conv_out_valid <= rst ? 1'b0 : (conv_data_valid & ~tie_off);
    if (conv_load_w) lw_cnt <= lw_cnt + 1;
    if (conv_load_b) lb_cnt <= lb_cnt + 1;
    if (conv_data_valid) dv_cnt <= dv_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byte_val(input int mode, input int n);
    if (mode == 0) return (n < 72) ? 8'(n + 1) : 8'(8'h10 + n - 72);
    if (mode == 1) return 8'hAA;
    return 8'(n * 3 + 5);
  endfunction

  task automatic send_cfg(input int nbytes, input int gap_every, input int mode);
    int w;
    for (int n = 0; n < nbytes; n++) begin
      if (gap_every > 0 && (n % gap_every) == 0) begin
        bus.cfg_valid = 1'b0;
        tick();
        tick();
      end
      bus.cfg_valid = 1'b1;
      bus.cfg_data  = byte_val(mode, n);
      w = 0;
      while (!bus.cfg_ready && w < 20) begin
        tick();
        w++;
      end
      if (w >= 20) check("cfg_ready_wait", 32'(bus.cfg_ready), 1);
      tick();
    end
    bus.cfg_valid = 1'b0;
  endtask

  initial begin
    logic [FBITS-1:0] ones;
    int base_lw, base_lb, base_dv, bad, n;
    ones = {32{8'h01}};
    bus.cfg_start    = 1'b0;
    bus.cfg_valid    = 1'b0;
    bus.cfg_data     = '0;
    bus.frame_valid  = 1'b0;
    bus.frame_data   = '0;
    bus.result_ready = 1'b1;

    // Reset state
    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_configured", 32'(configured), 0);
    check("rst_cfg_ready",  32'(bus.cfg_ready), 0);
    check("rst_frame_rdy",  32'(bus.frame_ready), 0);
    check("rst_res_valid",  32'(bus.result_valid), 0);
    check("rst_count",      32'(frame_count), 0);
    check("rst_err",        32'(err_timeout), 0);
    check("rst_weights",    32'(|conv_weights), 0);

    // 1: full configuration
    base_lw = lw_cnt; base_lb = lb_cnt;
    bus.cfg_start = 1'b1; tick(); bus.cfg_start = 1'b0;
    check("load_cfg_ready", 32'(bus.cfg_ready), 1);
    send_cfg(80, 0, 0);
    tick(); tick();
    check("cfg_w0",      32'(conv_weights[0 +: 8]), 'h01);
    check("cfg_w71",     32'(conv_weights[71*8 +: 8]), 'h48);
    check("cfg_b7",      32'(conv_biases[7*8 +: 8]), 'h17);
    check("cfg_load_w1", 32'(lw_cnt - base_lw), 1);
    check("cfg_load_b1", 32'(lb_cnt - base_lb), 1);
    check("cfg_done",    32'(configured), 1);
    check("ready_frdy",  32'(bus.frame_ready), 1);

    // 2: single frame
    base_dv = dv_cnt;
    bus.frame_valid = 1'b1; bus.frame_data = ones;
    tick();
    bus.frame_valid = 1'b0;
    check("issue_dv",   32'(conv_data_valid), 1);
    check("issue_din",  32'(conv_data_in == ones), 1);
    tick();
    check("wait_rv0",   32'(bus.result_valid), 0);
    tick();
    check("hold_rv1",   32'(bus.result_valid), 1);
    tick();
    check("f1_count",   32'(frame_count), 1);
    check("f1_dv_once", 32'(dv_cnt - base_dv), 1);

    // 3: back-pressure
    base_dv = dv_cnt;
    bus.result_ready = 1'b0;
    bus.frame_valid  = 1'b1; bus.frame_data = {32{8'h02}};
    tick(); tick(); tick();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.frame_ready !== 1'b0 || bus.result_valid !== 1'b1) bad++;
      tick();
    end
    check("bp_hold",      32'(bad), 0);
    check("bp_dv_once",   32'(dv_cnt - base_dv), 1);
    bus.result_ready = 1'b1;
    tick();
    check("bp_count",     32'(frame_count), 2);
    check("bp_frdy",      32'(bus.frame_ready), 1);
    tick();
    check("bp_next_dv",   32'(conv_data_valid), 1);
    bus.frame_valid = 1'b0;
    tick(); tick(); tick();
    check("bp_count3",    32'(frame_count), 3);

    // 4: timeout
    tie_off = 1'b1;
    bus.frame_valid = 1'b1;
    tick();
    bus.frame_valid = 1'b0;
    n = 0;
    while (!bus.frame_ready && n < 40) begin
      tick();
      n++;
    end
    check("tmo_cycles", 32'(n), 16);
    check("tmo_err",    32'(err_timeout), 1);
    check("tmo_count",  32'(frame_count), 3);
    check("tmo_norv",   32'(bus.result_valid), 0);
    bus.cfg_start = 1'b1; tick(); bus.cfg_start = 1'b0;
    check("tmo_clear",  32'(err_timeout), 0);
    check("recfg_deconf", 32'(configured), 0);
    tie_off = 1'b0;

    // 5: gapped, restarted configuration
    send_cfg(30, 3, 1);
    bus.cfg_start = 1'b1; tick(); bus.cfg_start = 1'b0;
    base_lw = lw_cnt;
    send_cfg(80, 4, 2);
    tick(); tick();
    check("rcfg_load_once", 32'(lw_cnt - base_lw), 1);
    check("rcfg_conf",      32'(configured), 1);
    check("rcfg_w0",        32'(conv_weights[0 +: 8]), 'h05);
    check("rcfg_w29",       32'(conv_weights[29*8 +: 8]), 'h5C);
    check("rcfg_b7",        32'(conv_biases[7*8 +: 8]), 'hF2);

    tie_off = 1'b1;
    bus.frame_valid = 1'b1; tick(); bus.frame_valid = 1'b0;
    tick();
    bus.cfg_start = 1'b1; tick(); bus.cfg_start = 1'b0;
    check("wait_start_conf", 32'(configured), 1);
    check("wait_start_crdy", 32'(bus.cfg_ready), 0);
    n = 0;
    while (!bus.frame_ready && n < 40) begin
      tick();
      n++;
    end
    check("wait_start_tmo", 32'(err_timeout), 1);
    tie_off = 1'b0;

    // 6: reset while holding a result
    bus.result_ready = 1'b0;
    bus.frame_valid  = 1'b1; tick(); bus.frame_valid = 1'b0;
    tick(); tick();
    check("pre_rst_hold", 32'(bus.result_valid), 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("mrst_rv",    32'(bus.result_valid), 0);
    check("mrst_frdy",  32'(bus.frame_ready), 0);
    check("mrst_crdy",  32'(bus.cfg_ready), 0);
    check("mrst_conf",  32'(configured), 0);
    check("mrst_count", 32'(frame_count), 0);
    check("mrst_err",   32'(err_timeout), 0);
    check("mrst_w",     32'(|conv_weights), 0);
    check("mrst_din",   32'(|conv_data_in), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
